// File: rtl/ecc_pkg.sv
// Shared definitions for the small-field ECC point-arithmetic control path:
// point-unit opcodes, kP sequencer state encoding and the default key width.
package ecc_pkg;

   localparam int KEY_W_DEF = 32;

   typedef enum logic [1:0] {
      OP_NOP  = 2'd0,
      OP_LOAD = 2'd1,
      OP_DBL  = 2'd2,
      OP_ADD  = 2'd3
   } op_e;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_BIT   = 3'd1,
      S_ISSUE = 3'd2,
      S_WAIT  = 3'd3,
      S_DONE  = 3'd4
   } state_e;

   // PH_END marks a bit whose ops are finished, so BIT only has to advance.
   typedef enum logic [1:0] {
      PH_DBL = 2'd0,
      PH_ADD = 2'd1,
      PH_END = 2'd2
   } phase_e;

   function automatic int idx_width(input int w);
      return (w <= 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/ecc_kp_bitsel.sv
// Key register and MSB-first bit selector for the kP sequencer: holds the
// captured scalar, the bit index down-counter, the current bit and a last-bit flag.
module ecc_kp_bitsel #(
   parameter int KEY_W = 32,
   parameter int IDX_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             step,
   input  logic [KEY_W-1:0] key,
   output logic             bit_val,
   output logic             last
);

   logic [KEY_W-1:0] key_q;
   logic [IDX_W-1:0] idx;

   // The index never steps below zero; the sequencer finishes on the last bit.
   always_ff @(posedge clk) begin
      if (reset) begin
         key_q <= '0;
         idx   <= '0;
      end else if (load) begin
         key_q <= key;
         idx   <= IDX_W'(KEY_W - 1);
      end else if (step && (idx != '0)) begin
         idx <= idx - 1'b1;
      end
   end

   assign bit_val = key_q[idx];
   assign last    = (idx == '0);

endmodule

// File: rtl/ecc_kp_sequencer.sv
// Left-to-right double-and-add sequencer for kP driving the shared point unit.
// Define ECC_KP_CONST_TIME_EN for the constant-time variant using dummy (uncommitted) ops.
module ecc_kp_sequencer
   import ecc_pkg::*;
#(
   parameter int KEY_W = KEY_W_DEF,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [KEY_W-1:0] key,
   output logic             busy,
   output logic             done,
   output logic             result_inf,
   output logic             op_valid,
   input  logic             op_ready,
   output logic [1:0]       op_code,
   output logic             op_commit,
   input  logic             res_valid,
   input  logic             res_inf,
   output logic [CNT_W-1:0] op_count
);

   localparam int IDX_W = idx_width(KEY_W);

   state_e           state, state_d;
   phase_e           ph, ph_d;
   op_e              op_q, op_d;
   logic             inf, inf_d;
   logic             commit_q, commit_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             res_inf_q, res_inf_d;
   logic             load, step;
   logic             bit_val, last;
   logic             issue;
   op_e              sel_op;
   logic             sel_commit;

   ecc_kp_bitsel #(
      .KEY_W (KEY_W),
      .IDX_W (IDX_W)
   ) u_bitsel (
      .clk     (clk),
      .reset   (reset),
      .load    (load),
      .step    (step),
      .key     (key),
      .bit_val (bit_val),
      .last    (last)
   );

   // Op choice for the current bit and phase; no issue means the bit is finished.
   always_comb begin
      issue      = 1'b0;
      sel_op     = OP_NOP;
      sel_commit = 1'b0;
`ifdef ECC_KP_CONST_TIME_EN
      case (ph)
         PH_DBL: begin
            issue      = 1'b1;
            sel_op     = OP_DBL;
            sel_commit = !inf;
         end
         PH_ADD: begin
            issue      = 1'b1;
            sel_op     = (bit_val && inf) ? OP_LOAD : OP_ADD;
            sel_commit = bit_val;
         end
         default: ;
      endcase
`else
      if (ph != PH_END) begin
         if (inf) begin
            if (bit_val) begin
               issue      = 1'b1;
               sel_op     = OP_LOAD;
               sel_commit = 1'b1;
            end
         end else if (ph == PH_DBL) begin
            issue      = 1'b1;
            sel_op     = OP_DBL;
            sel_commit = 1'b1;
         end else if (bit_val) begin
            issue      = 1'b1;
            sel_op     = OP_ADD;
            sel_commit = 1'b1;
         end
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         ph        <= PH_DBL;
         op_q      <= OP_NOP;
         inf       <= 1'b1;
         commit_q  <= 1'b0;
         count_q   <= '0;
         res_inf_q <= 1'b0;
      end else begin
         state     <= state_d;
         ph        <= ph_d;
         op_q      <= op_d;
         inf       <= inf_d;
         commit_q  <= commit_d;
         count_q   <= count_d;
         res_inf_q <= res_inf_d;
      end
   end

   always_comb begin
      state_d   = state;
      ph_d      = ph;
      op_d      = op_q;
      inf_d     = inf;
      commit_d  = commit_q;
      count_d   = count_q;
      res_inf_d = res_inf_q;
      load      = 1'b0;
      step      = 1'b0;
      busy      = (state != S_IDLE);
      done      = 1'b0;
      op_valid  = 1'b0;
      op_code   = OP_NOP;
      op_commit = 1'b0;

      case (state)
         S_IDLE: begin
            if (start) begin
               load      = 1'b1;
               inf_d     = 1'b1;
               ph_d      = PH_DBL;
               count_d   = '0;
               res_inf_d = 1'b0;
               state_d   = S_BIT;
            end
         end
         S_BIT: begin
            if (issue) begin
               op_d     = sel_op;
               commit_d = sel_commit;
               state_d  = S_ISSUE;
            end else if (last) begin
               res_inf_d = inf;
               state_d   = S_DONE;
            end else begin
               step = 1'b1;
               ph_d = PH_DBL;
            end
         end
         S_ISSUE: begin
            op_valid  = 1'b1;
            op_code   = op_q;
            op_commit = commit_q;
            if (op_ready) begin
               state_d = S_WAIT;
            end
         end
         // A dummy op's result never touches inf or the committed-op count.
         S_WAIT: begin
            if (res_valid) begin
               if (commit_q) begin
                  inf_d = res_inf;
                  if (count_q != '1) begin
                     count_d = count_q + 1'b1;
                  end
               end
               ph_d    = (op_q == OP_DBL) ? PH_ADD : PH_END;
               state_d = S_BIT;
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign result_inf = res_inf_q;
   assign op_count   = count_q;

endmodule

// File: tb/tb_ecc_kp_sequencer.sv
// Bench for ecc_kp_sequencer: directed vector table, random keys against a
// double-and-add reference model, and a mid-run reset sequence.
module tb_ecc_kp_sequencer;

   localparam int KW   = 32;
   localparam int CW   = 5;
   localparam int CMAX = (1 << CW) - 1;
   localparam logic [1:0] C_LOAD = 2'd1;
   localparam logic [1:0] C_DBL  = 2'd2;
   localparam logic [1:0] C_ADD  = 2'd3;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [KW-1:0] key;
   logic          busy, done, result_inf;
   logic          op_valid, op_ready, op_commit;
   logic [1:0]    op_code;
   logic          res_valid, res_inf;
   logic [CW-1:0] op_count;

   always #5 clk = ~clk;

   ecc_kp_sequencer #(
      .KEY_W (KW),
      .CNT_W (CW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .key        (key),
      .busy       (busy),
      .done       (done),
      .result_inf (result_inf),
      .op_valid   (op_valid),
      .op_ready   (op_ready),
      .op_code    (op_code),
      .op_commit  (op_commit),
      .res_valid  (res_valid),
      .res_inf    (res_inf),
      .op_count   (op_count)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   int cfg_lat   = 1;
   int cfg_stall = 0;
   bit cfg_noise = 1'b0;
   bit inj [0:255];

   logic [2:0] obs_ops [$];
   logic [2:0] exp_ops [$];
   bit  exp_inf;
   int  exp_cnt;
   int  op_idx;
   bit  stable_bad;

   int obs_done_cnt, obs_cycles;
   bit obs_rinf, obs_timeout;

   typedef struct {
      logic [KW-1:0] k;
      int            lat;
      int            stall;
      int            inj_at;
      int            exp_n;
      int            exp_cnt;
      bit            exp_rinf;
   } vec_t;

   vec_t vecs [4];

   task automatic check_output(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Point-unit stand-in: stalls op_ready, returns results after cfg_lat cycles.
   initial begin : responder
      int         countdown;
      int         stall_cnt;
      bit         stalling;
      logic [2:0] first_op;
      countdown = 0;
      stall_cnt = 0;
      stalling  = 1'b0;
      first_op  = '0;
      op_ready  = 1'b0;
      res_valid = 1'b0;
      res_inf   = 1'b0;
      forever begin
         @(negedge clk);
         res_valid = 1'b0;
         res_inf   = cfg_noise ? 1'($urandom % 2) : 1'b0;
         if (countdown > 0) begin
            countdown--;
            if (countdown == 0) begin
               res_valid = 1'b1;
               res_inf   = inj[(op_idx - 1) & 255];
            end
         end
         if (op_valid) begin
            if (!stalling) begin
               stalling  = 1'b1;
               first_op  = {op_commit, op_code};
               stall_cnt = 0;
            end else if ({op_commit, op_code} !== first_op) begin
               stable_bad = 1'b1;
            end
            if (stall_cnt < cfg_stall) begin
               op_ready = 1'b0;
               stall_cnt++;
            end else begin
               op_ready = 1'b1;
               obs_ops.push_back(first_op);
               op_idx++;
               countdown = cfg_lat;
               stalling  = 1'b0;
            end
         end else begin
            if (stalling) stable_bad = 1'b1;
            stalling = 1'b0;
            op_ready = cfg_noise ? 1'($urandom % 2) : 1'b0;
            if (cfg_noise && countdown == 0 && !res_valid) begin
               res_valid = ($urandom % 4 == 0);
            end
         end
      end
   end

   // Reference: R starts at infinity; per bit R:=2R then R:=R+P when the bit is set.
   task automatic model_run(input logic [KW-1:0] k);
      bit r_inf;
      int n;
      int commits;
      exp_ops.delete();
      r_inf   = 1'b1;
      n       = 0;
      commits = 0;
      for (int i = KW - 1; i >= 0; i--) begin
`ifdef ECC_KP_CONST_TIME_EN
         exp_ops.push_back({~r_inf, C_DBL});
         if (!r_inf) begin
            r_inf = inj[n];
            commits++;
         end
         n++;
         if (k[i]) begin
            exp_ops.push_back({1'b1, r_inf ? C_LOAD : C_ADD});
            r_inf = inj[n];
            commits++;
         end else begin
            exp_ops.push_back({1'b0, C_ADD});
         end
         n++;
`else
         if (!r_inf) begin
            exp_ops.push_back({1'b1, C_DBL});
            r_inf = inj[n];
            n++;
            commits++;
         end
         if (k[i]) begin
            exp_ops.push_back({1'b1, r_inf ? C_LOAD : C_ADD});
            r_inf = inj[n];
            n++;
            commits++;
         end
`endif
      end
      exp_inf = r_inf;
      exp_cnt = (commits > CMAX) ? CMAX : commits;
   endtask

   task automatic apply_stimulus(input logic [KW-1:0] k, input int lat, input int stall,
                                 input bit noise, input string tag);
      int cyc;
      cfg_lat   = lat;
      cfg_stall = stall;
      cfg_noise = noise;
      obs_ops.delete();
      op_idx       = 0;
      stable_bad   = 1'b0;
      obs_done_cnt = 0;
      obs_cycles   = 0;
      obs_rinf     = 1'b0;
      obs_timeout  = 1'b0;
      @(negedge clk);
      key   = k;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc   = 1;
      check_output({tag, ".busy_after_start"}, busy, 1);
      forever begin
         if (done) begin
            obs_done_cnt++;
            obs_rinf   = result_inf;
            obs_cycles = cyc;
            start      = noise;
            key        = $urandom;
         end else if (obs_done_cnt > 0) begin
            start = 1'b0;
            break;
         end else begin
            start = noise && ($urandom % 4 == 0);
            if (start) key = $urandom;
         end
         if (cyc >= 5000) begin
            obs_timeout = 1'b1;
            start       = 1'b0;
            break;
         end
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic check_vec(input logic [KW-1:0] k, input int lat, input int stall,
                            input bit noise, input string tag);
      int mism;
      int nmin;
      model_run(k);
      apply_stimulus(k, lat, stall, noise, tag);
      if (obs_timeout) begin
         check_output({tag, ".timeout"}, 1, 0);
         reset = 1'b1;
         @(negedge clk);
         reset = 1'b0;
         return;
      end
      check_output({tag, ".done_pulses"}, obs_done_cnt, 1);
      check_output({tag, ".cycles"}, obs_cycles, KW + 1 + exp_ops.size() * (2 + stall + lat));
      check_output({tag, ".result_inf_at_done"}, obs_rinf, exp_inf);
      check_output({tag, ".result_inf_held"}, result_inf, exp_inf);
      check_output({tag, ".op_count"}, op_count, exp_cnt);
      check_output({tag, ".busy_after_done"}, busy, 0);
      check_output({tag, ".num_ops"}, obs_ops.size(), exp_ops.size());
      mism = 0;
      nmin = (obs_ops.size() < exp_ops.size()) ? obs_ops.size() : exp_ops.size();
      for (int i = 0; i < nmin; i++) begin
         if (obs_ops[i] !== exp_ops[i]) mism++;
      end
      check_output({tag, ".op_stream_diffs"}, mism, 0);
      check_output({tag, ".req_stable"}, stable_bad, 0);
   endtask

   initial begin
      int  wait_cyc;
      bit  idle_bad;
`ifdef ECC_KP_CONST_TIME_EN
      int  cyc_a;
`endif
`ifdef ECC_KP_CONST_TIME_EN
      vecs[0] = '{32'd5,          3, 0, -1, 64,  4, 1'b0};
      vecs[1] = '{32'd0,          2, 0, -1, 64,  0, 1'b1};
      vecs[2] = '{32'd3,          2, 0, 62, 64,  3, 1'b0};
      vecs[3] = '{32'hFFFF_FFFF,  2, 5, -1, 64, 31, 1'b0};
`else
      vecs[0] = '{32'd5,          3, 0, -1,  4,  4, 1'b0};
      vecs[1] = '{32'd0,          2, 0, -1,  0,  0, 1'b1};
      vecs[2] = '{32'd3,          2, 0,  1,  3,  3, 1'b0};
      vecs[3] = '{32'hFFFF_FFFF,  2, 5, -1, 63, 31, 1'b0};
`endif
      reset = 1'b1;
      start = 1'b0;
      key   = '0;
      for (int i = 0; i < 256; i++) inj[i] = 1'b0;
      repeat (3) @(negedge clk);
      check_output("reset_state",
                   {busy, done, op_valid, op_code, op_commit, result_inf, op_count}, 0);
      reset = 1'b0;

      for (int v = 0; v < 4; v++) begin
         for (int i = 0; i < 256; i++) inj[i] = 1'b0;
         if (vecs[v].inj_at >= 0) inj[vecs[v].inj_at] = 1'b1;
         check_vec(vecs[v].k, vecs[v].lat, vecs[v].stall, 1'b0, $sformatf("vec%0d", v));
         check_output($sformatf("vec%0d.table_num_ops", v), obs_ops.size(), vecs[v].exp_n);
         check_output($sformatf("vec%0d.table_op_count", v), op_count, vecs[v].exp_cnt);
         check_output($sformatf("vec%0d.table_result_inf", v), obs_rinf, vecs[v].exp_rinf);
      end

`ifndef ECC_KP_CONST_TIME_EN
      for (int i = 0; i < 256; i++) inj[i] = 1'b0;
      check_vec(32'd5, 3, 0, 1'b0, "key5_seq");
      check_output("key5_seq.ops",
                   (obs_ops.size() == 4) ? {obs_ops[0], obs_ops[1], obs_ops[2], obs_ops[3]} : 12'h0,
                   {1'b1, C_LOAD, 1'b1, C_DBL, 1'b1, C_DBL, 1'b1, C_ADD});
`else
      for (int i = 0; i < 256; i++) inj[i] = 1'b0;
      check_vec(32'd5, 2, 0, 1'b0, "ct_key5");
      cyc_a = obs_cycles;
      check_output("ct_key5.op_count", op_count, 4);
      check_vec(32'hFFFF_FFFF, 2, 0, 1'b0, "ct_keyff");
      check_output("ct_keyff.num_ops", obs_ops.size(), 64);
      check_output("ct_equal_cycles", obs_cycles, cyc_a);
`endif

      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < 256; i++) inj[i] = ($urandom % 6 == 0);
         check_vec($urandom >> $urandom_range(0, 31), $urandom_range(1, 4),
                   $urandom_range(0, 3), 1'b1, $sformatf("rand%0d", r));
      end

      // Abort in WAIT with a result still in flight, then restart with key=1.
      for (int i = 0; i < 256; i++) inj[i] = 1'b0;
      cfg_lat   = 6;
      cfg_stall = 0;
      cfg_noise = 1'b0;
      obs_ops.delete();
      op_idx = 0;
      @(negedge clk);
      key   = 32'd5;
      start = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      wait_cyc = 0;
      while (obs_ops.size() == 0 && wait_cyc < 200) begin
         @(negedge clk);
         wait_cyc++;
      end
      check_output("abort.handshake_seen", obs_ops.size(), 1);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_output("abort.reset_outputs",
                   {busy, done, op_valid, op_code, op_commit, result_inf, op_count}, 0);
      idle_bad = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (busy || done || op_valid || op_count != 0) idle_bad = 1'b1;
      end
      check_output("abort.late_result_ignored", idle_bad, 0);
      check_vec(32'd1, 2, 0, 1'b0, "post_reset_key1");
`ifdef ECC_KP_CONST_TIME_EN
      check_output("post_reset_key1.count", op_count, 1);
`else
      check_output("post_reset_key1.first_op",
                   (obs_ops.size() > 0) ? obs_ops[0] : 3'd0, {1'b1, C_LOAD});
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/ecc_kp_sequencer.md
Name: ecc_kp_sequencer

Overview:
Control-only sequencer for scalar multiplication kP on the small-field ECC datapath. It scans the key MSB-first using left-to-right double-and-add, one bit at a time. For each bit it issues LOAD / DBL / ADD operations to the shared point-arithmetic unit over a valid/ready request and result handshake. It tracks point-at-infinity for accumulator R, sits between the serial input-capture logic and the point unit, and raises done for the serial output stage.

Parameters:
KEY_W, 32, scalar width in bits; legal range 2..64.
CNT_W, 8, width of op_count.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  start pulse; sampled only in IDLE
key  in  KEY_W  scalar k; captured on accepted start
busy  out  1  high from the cycle after accepted start through the DONE cycle
done  out  1  one-cycle pulse when kP is final
result_inf  out  1  final R is the point at infinity; valid while done=1, held until next start
op_valid  out  1  request to point unit
op_ready  in  1  point unit accepts request
op_code  out  2  0 NOP, 1 LOAD (R:=P), 2 DBL (R:=2R), 3 ADD (R:=R+P)
op_commit  out  1  unit writes its result into R only when 1
res_valid  in  1  point unit result strobe; one per accepted op
res_inf  in  1  result is infinity; qualified by res_valid
op_count  out  CNT_W  committed ops since start; saturates at all-ones

Behaviour:
- Reset values:
  - state IDLE; all outputs 0 except op_code=NOP.
  - Internal inf flag 1, idx 0.
  - Reset mid-operation aborts immediately, with no done.
  - Any in-flight res_valid after reset is ignored, because it arrives while in IDLE.
- States: IDLE, BIT, ISSUE, WAIT, DONE. A single op is outstanding at most.
- IDLE, start=1:
  - key captured, idx:=KEY_W-1, inf:=1, op_count:=0, result_inf:=0.
  - Go to BIT; busy=1 from the next cycle.
- BIT (evaluates key[idx]; the phase flag ph selects DBL-phase or ADD-phase, ph=DBL on entry to each new bit):
  - inf=1, bit=1: op LOAD, go to ISSUE.
  - inf=1, bit=0: no op; advance.
  - inf=0, ph=DBL: op DBL, go to ISSUE.
  - inf=0, ph=ADD, bit=1: op ADD, go to ISSUE.
  - inf=0, ph=ADD, bit=0: advance.
- Bit handling after an op:
  - After a committed DBL with bit=1: return to BIT with ph=ADD.
  - If DBL returned res_inf=1: the ADD phase re-evaluates with inf=1, so a LOAD is issued instead of ADD.
  - After LOAD or ADD: advance.
- Advance:
  - idx=0 goes to DONE.
  - Otherwise idx:=idx-1, ph:=DBL, go to BIT.
  - Costs 1 cycle in BIT.
- ISSUE:
  - op_valid=1; op_code and op_commit held stable until op_ready=1 (the handshake cycle).
  - Then go to WAIT with op_valid=0.
  - res_valid arriving in the same cycle as the handshake is not allowed; the unit guarantees at least 1 cycle of latency.
- WAIT, res_valid=1:
  - If op_commit=1: inf:=res_inf, and op_count increments.
  - Return to BIT.
- DONE:
  - done=1 and result_inf=inf for one cycle; busy=1.
  - Next state IDLE.
  - start in DONE is ignored.
- Boundary cases:
  - start while busy: ignored.
  - key=0: no ops issued; done exactly KEY_W+1 cycles after start with result_inf=1.
  - key=1: single LOAD.
  - res_valid outside WAIT: ignored.
  - op_ready high outside ISSUE: ignored.

Optional Feature:
ECC_KP_CONST_TIME_EN
- Defined:
  - Every bit issues exactly one DBL then one ADD, regardless of key bit or inf.
  - When the real algorithm would skip an op, it is issued with op_commit=0 (dummy) and op_code DBL/ADD.
  - When inf=1 and bit=1, ADD is replaced by LOAD with commit=1.
  - The op count is always 2*KEY_W, so timing is key-independent given a fixed unit latency.
  - op_count counts committed ops only.
- Undefined: behaviour exactly as above; op_commit is always 1.

Decomposition:
- Shared package ecc_pkg holds:
  - op_code enum constants OP_NOP/OP_LOAD/OP_DBL/OP_ADD.
  - State encoding.
  - Default KEY_W.
- One natural sub-module, ecc_kp_bitsel: captured key register, idx down-counter, current bit, and last-bit flag.
- The FSM stays in ecc_kp_sequencer.

Test Plan:
1. KEY_W=32, key=5, unit latency 3, op_ready=1 -> op stream LOAD, DBL, DBL, ADD; done once; result_inf=0; op_count=4.
2. key=0 -> no op_valid ever; done 33 cycles after start; result_inf=1; op_count=0.
3. key=3, unit returns res_inf=1 on the DBL -> following op is LOAD (not ADD); final result_inf=0; op_count=3.
4. key=0xFFFFFFFF, op_ready low for 5 cycles on each request -> op_valid/op_code stable while stalled; 63 ops total (1 LOAD, 31 DBL, 31 ADD).
5. reset asserted in WAIT mid-run, with a late res_valid 2 cycles later -> IDLE, all outputs 0, late result ignored; a new start with key=1 yields a single LOAD, then done.
6. With ECC_KP_CONST_TIME_EN, key=5 vs key=0xFFFFFFFF, fixed latency -> identical cycle count from start to done; op_valid count=64; op_count for key=5 equals 4.
